// File: rtl/tx_sched_pkg.sv
// Shared encodings and symbol defaults for the transmit lane scheduler.
package tx_sched_pkg;

  typedef enum logic [1:0] {
    RESET_S = 2'b00,
    INIT    = 2'b01,
    RUN     = 2'b10
  } sched_state_e;

  localparam int          NUM_LANES    = 4;
  localparam logic [7:0]  COM_DEF      = 8'hBC;
  localparam logic [7:0]  IDLE_DEF     = 8'h7C;
  localparam int          INIT_COM_DEF = 4;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin pick: first valid lane at or after pointer.
module rr_arbiter4 (
  input  logic [3:0] valid,
  input  logic [1:0] pointer,
  input  logic       enable,
  output logic [3:0] grant,
  output logic [1:0] grant_idx
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < 4; k++) begin
      idx = pointer + 2'(k);
      if (enable && !found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/tx_lane_scheduler.sv
// Link training FSM plus round-robin lane scheduler feeding the serializer.
module tx_lane_scheduler
  import tx_sched_pkg::*;
#(
  parameter int                DATA_W         = 8,
  parameter logic [DATA_W-1:0] COM            = COM_DEF,
  parameter logic [DATA_W-1:0] IDLE           = IDLE_DEF,
  parameter int                INIT_COM_COUNT = INIT_COM_DEF
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic              valid_0,
  input  logic              valid_1,
  input  logic              valid_2,
  input  logic              valid_3,
  output logic              ready_0,
  output logic              ready_1,
  output logic              ready_2,
  output logic              ready_3,
  input  logic              link_up,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [1:0]        lane_id,
  output logic [1:0]        state
);

  localparam logic [3:0] CNT_MAX = 4'(INIT_COM_COUNT);

  sched_state_e state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic         vld_q, vld_d;
  logic [1:0]   lane_q, lane_d;

  logic [NUM_LANES-1:0][DATA_W-1:0] lane_data;
  logic [NUM_LANES-1:0] valid_vec, grant;
  logic [1:0]   grant_idx;
  logic         grant_any;

  assign lane_data = {in3, in2, in1, in0};
  assign valid_vec = {valid_3, valid_2, valid_1, valid_0};

  // A link drop suppresses any grant in the same cycle.
  rr_arbiter4 u_arb (
    .valid     (valid_vec),
    .pointer   (ptr_q),
    .enable    ((state_q == RUN) && link_up),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign grant_any = |grant;
  assign {ready_3, ready_2, ready_1, ready_0} = grant;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    vld_d   = vld_q;
    lane_d  = lane_q;
    case (state_q)
      RESET_S: state_d = INIT;
      INIT: begin
        data_d = COM;
        vld_d  = 1'b0;
        lane_d = '0;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 4'd1;
        if (link_up && (cnt_d == CNT_MAX)) state_d = RUN;
      end
      RUN: begin
        if (!link_up) begin
          data_d  = COM;
          vld_d   = 1'b0;
          lane_d  = '0;
          cnt_d   = '0;
          state_d = INIT;
        end else if (grant_any) begin
          data_d = lane_data[grant_idx];
          vld_d  = 1'b1;
          lane_d = grant_idx;
          ptr_d  = grant_idx + 2'd1;
        end else begin
          data_d = IDLE;
          vld_d  = 1'b0;
          lane_d = '0;
        end
      end
      default: state_d = RESET_S;
    endcase
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state_q <= RESET_S;
      cnt_q   <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      lane_q  <= lane_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = vld_q;
  assign lane_id   = lane_q;
  assign state     = state_q;

endmodule

// File: tb/tb_tx_lane_scheduler.sv
// Scoreboard bench: stimulus pushes hand-computed post-edge outputs, a monitor pops and compares.
module tb_tx_lane_scheduler;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic [7:0] in0, in1, in2, in3;
  logic       valid_0, valid_1, valid_2, valid_3;
  logic       ready_0, ready_1, ready_2, ready_3;
  logic       link_up;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] lane_id;
  logic [1:0] state;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
    logic [1:0] l;
    logic [1:0] s;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_out  = 0;

  tx_lane_scheduler dut (
    .clk_4f(clk_4f), .reset(reset),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .valid_0(valid_0), .valid_1(valid_1), .valid_2(valid_2), .valid_3(valid_3),
    .ready_0(ready_0), .ready_1(ready_1), .ready_2(ready_2), .ready_3(ready_3),
    .link_up(link_up), .data_out(data_out), .valid_out(valid_out),
    .lane_id(lane_id), .state(state)
  );

  always #5 clk_4f = ~clk_4f;

  // Monitor: every registered output after an edge is checked against the queue head.
  always @(posedge clk_4f) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (data_out !== e.d || valid_out !== e.v || lane_id !== e.l || state !== e.s) begin
        n_miss++;
        $display("FAIL out[%0d] got data=%h vld=%b lane=%0d st=%b want data=%h vld=%b lane=%0d st=%b",
                 n_out, data_out, valid_out, lane_id, state, e.d, e.v, e.l, e.s);
      end
      n_out++;
    end
  end

  task automatic chk_rdy(input logic [3:0] er, input string tag);
    n_vec++;
    if ({ready_3, ready_2, ready_1, ready_0} !== er) begin
      n_miss++;
      $display("FAIL %s ready got %b want %b", tag, {ready_3, ready_2, ready_1, ready_0}, er);
    end
  endtask

  task automatic step(input logic [3:0] v, input logic lu, input logic rst,
                      input logic [3:0] er, input logic [7:0] ed, input logic ev,
                      input logic [1:0] el, input logic [1:0] es);
    exp_t e;
    @(negedge clk_4f);
    {valid_3, valid_2, valid_1, valid_0} = v;
    link_up = lu;
    reset   = rst;
    #1;
    chk_rdy(er, "step");
    e.d = ed; e.v = ev; e.l = el; e.s = es;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    reset = 1'b0; link_up = 1'b0;
    {valid_3, valid_2, valid_1, valid_0} = 4'h0;
    in0 = 8'h10; in1 = 8'h21; in2 = 8'h32; in3 = 8'h43;

    // reset held 3 cycles
    repeat (3) step(4'h0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 2'd0, 2'b00);

    // bring-up: RESET_S edge, then 4 COMs, ready low despite valid
    step(4'hF, 1'b1, 1'b1, 4'h0, 8'h00, 1'b0, 2'd0, 2'b01);
    repeat (3) step(4'hF, 1'b1, 1'b1, 4'h0, 8'hBC, 1'b0, 2'd0, 2'b01);
    step(4'hF, 1'b1, 1'b1, 4'h0, 8'hBC, 1'b0, 2'd0, 2'b10);

    // full load: two rotations, pointer back at 0
    repeat (2) begin
      step(4'hF, 1'b1, 1'b1, 4'b0001, 8'h10, 1'b1, 2'd0, 2'b10);
      step(4'hF, 1'b1, 1'b1, 4'b0010, 8'h21, 1'b1, 2'd1, 2'b10);
      step(4'hF, 1'b1, 1'b1, 4'b0100, 8'h32, 1'b1, 2'd2, 2'b10);
      step(4'hF, 1'b1, 1'b1, 4'b1000, 8'h43, 1'b1, 2'd3, 2'b10);
    end

    // sparse valid on lanes 1 and 3
    repeat (2) begin
      step(4'b1010, 1'b1, 1'b1, 4'b0010, 8'h21, 1'b1, 2'd1, 2'b10);
      step(4'b1010, 1'b1, 1'b1, 4'b1000, 8'h43, 1'b1, 2'd3, 2'b10);
    end
    step(4'h0, 1'b1, 1'b1, 4'h0, 8'h7C, 1'b0, 2'd0, 2'b10);

    // link loss mid-traffic: one COM from RUN, then 4 training COMs
    step(4'hF, 1'b1, 1'b1, 4'b0001, 8'h10, 1'b1, 2'd0, 2'b10);
    step(4'hF, 1'b0, 1'b1, 4'h0, 8'hBC, 1'b0, 2'd0, 2'b01);
    repeat (3) step(4'hF, 1'b1, 1'b1, 4'h0, 8'hBC, 1'b0, 2'd0, 2'b01);
    step(4'hF, 1'b1, 1'b1, 4'h0, 8'hBC, 1'b0, 2'd0, 2'b10);
    step(4'hF, 1'b1, 1'b1, 4'b0010, 8'h21, 1'b1, 2'd1, 2'b10);
    step(4'hF, 1'b1, 1'b1, 4'b0100, 8'h32, 1'b1, 2'd2, 2'b10);

    // async reset between edges while traffic is pending
    @(negedge clk_4f);
    {valid_3, valid_2, valid_1, valid_0} = 4'hF;
    link_up = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk_rdy(4'h0, "async_rst");
    n_vec++;
    if (data_out !== 8'h00 || valid_out !== 1'b0 || lane_id !== 2'd0 || state !== 2'b00) begin
      n_miss++;
      $display("FAIL async_rst got data=%h vld=%b lane=%0d st=%b want 00/0/0/00",
               data_out, valid_out, lane_id, state);
    end
    e.d = 8'h00; e.v = 1'b0; e.l = 2'd0; e.s = 2'b00;
    exp_q.push_back(e);

    // late link: release with link down, COM repeats, state stays INIT
    step(4'hF, 1'b0, 1'b1, 4'h0, 8'h00, 1'b0, 2'd0, 2'b01);
    repeat (10) step(4'hF, 1'b0, 1'b1, 4'h0, 8'hBC, 1'b0, 2'd0, 2'b01);
    step(4'hF, 1'b1, 1'b1, 4'h0, 8'hBC, 1'b0, 2'd0, 2'b10);

    // pointer restarted at lane 0; new data on lane 0
    in0 = 8'h5A;
    step(4'hF, 1'b1, 1'b1, 4'b0001, 8'h5A, 1'b1, 2'd0, 2'b10);
    step(4'b0100, 1'b1, 1'b1, 4'b0100, 8'h32, 1'b1, 2'd2, 2'b10);
    step(4'h0, 1'b1, 1'b1, 4'h0, 8'h7C, 1'b0, 2'd0, 2'b10);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk_4f);
    if (exp_q.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tx_lane_scheduler.md
# tx_lane_scheduler

Round-robin scheduler for the four 8-bit transmit lanes of the PHY transmit path. Runs in the clk_4f domain, brings the link up with a COM training sequence, then grants one lane per cycle and forwards its byte, tagged with the lane number, to the parallel-to-serial stage. When no lane has data it emits IDLE symbols. It replaces the fixed-order lane multiplexing, so the serializer sees a single scheduled byte stream.

## Interface
- DATA_W, 8, byte width of every lane and of data_out
- COM, 8'hBC, training/comma symbol
- IDLE, 8'h7C, filler symbol sent in RUN when no lane is valid
- INIT_COM_COUNT, 4, minimum COM symbols before RUN (1..15)

Ports:
- clk_4f  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 forces all state and outputs to reset values immediately
- in0..in3  in  8 each  lane data bytes
- valid_0..valid_3  in  1 each  lane has a byte
- ready_0..ready_3  out  1 each  lane granted this cycle (combinational)
- link_up  in  1  receiver reports lock; already synchronized to clk_4f
- data_out  out  8  registered byte to serializer
- valid_out  out  1  data_out carries lane data (0 for COM/IDLE)
- lane_id  out  2  source lane of data_out when valid_out=1, else 0
- state  out  2  current FSM state: 00 RESET_S, 01 INIT, 10 RUN

## Operation
- Reset values: data_out=0, valid_out=0, lane_id=0, state=00, ready_*=0, round-robin pointer=0, COM counter=0.
- RESET_S: lasts one edge after reset release, then moves unconditionally to INIT. Outputs hold reset values.
- INIT:
  - Each edge registers data_out=COM, valid_out=0, lane_id=0.
  - The COM counter increments and saturates at INIT_COM_COUNT.
  - Moves to RUN on the edge that registers the INIT_COM_COUNT-th COM if link_up=1.
  - Otherwise stays in INIT sending COM; it then moves to RUN on the first edge with link_up=1.
  - ready_* = 0 throughout.
- RUN:
  - Grant goes to the first lane i with valid_i=1, searching pointer, pointer+1, … mod 4.
  - ready_i=1 for that lane only, and only while link_up=1. Transfer occurs when valid_i & ready_i.
  - On a transfer edge: data_out=in_i, valid_out=1, lane_id=i, pointer ← (i+1) mod 4.
  - With no valid lane: data_out=IDLE, valid_out=0, lane_id=0, pointer unchanged.
- link_up=0 while in RUN:
  - No grant that cycle. data_out=COM, valid_out=0.
  - Next state is INIT with the COM counter cleared, so the full training sequence repeats.
- reset=0 at any time: asynchronous return to reset values. A byte in flight is dropped; no partial transfer is reported.

## Timing
- ready_* is combinational from valid_*, pointer, state and link_up. It has no dependence on data inputs.
- Latency: a handshake in cycle n appears on data_out/valid_out/lane_id after edge n, stable through cycle n+1.
- Throughput: one byte per clk_4f cycle. With all four lanes continuously valid, the grant order is 0,1,2,3,0…
- Startup: after release with link_up=1, state reads 01 after edge 1. data_out=COM for INIT_COM_COUNT cycles, then the first RUN grant.
- Simultaneous events:
  - valid_i rising in the same cycle the pointer passes i: lane i waits a full rotation only if another valid lane precedes it in search order.
  - A link_up drop takes priority over any grant.

## Structure
- Package tx_sched_pkg holds the state encodings (RESET_S, INIT, RUN) and the COM/IDLE defaults.
- Sub-module rr_arbiter4 is purely combinational: valid[3:0], pointer[1:0], enable → grant one-hot[3:0], grant_idx[1:0].
- The top level holds the FSM, COM counter, pointer register and output registers.

## Test plan
- Reset and bring-up: reset=0 for 3 cycles, then 1, link_up=1 → state 00→01. data_out=8'hBC for exactly 4 cycles, then state=10. ready_*=0 throughout INIT.
- Late link: link_up=0 for 10 cycles after release → data_out stays 8'hBC, state stays 01. Raising link_up gives state=10 on the next edge.
- Full load: all valid, in0..3=8'h10,8'h21,8'h32,8'h43 → data_out sequence 10,21,32,43,10… with lane_id 0,1,2,3,0… and valid_out=1 every cycle.
- Fairness with sparse valid: only valid_1 and valid_3 high, pointer=0 → grants 1,3,1,3. Dropping all valid gives data_out=8'h7C, valid_out=0.
- Link loss mid-RUN: link_up=0 for one cycle during traffic → no ready that cycle, data_out=8'hBC, state→01. 4 COMs are required again before grants resume.
- Async reset mid-stream: reset=0 between clock edges during traffic → data_out=0, valid_out=0, ready_*=0, state=00 immediately. After release the grant pointer starts at lane 0.
